// File: rtl/tile_stat_accum_pkg.sv
// tile_stat_pkg: shared widths, state encoding and result record for tile_stat_accum.
// Optional mean field is controlled by TILE_STAT_MEAN_EN.
package tile_stat_pkg;
  function automatic int idx_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
  function automatic int sum_w(input int tw, input int th);
    return 8 + $clog2(tw * th);
  endfunction
  localparam int DEF_IMG_WIDTH   = 32;
  localparam int DEF_IMG_HEIGHT  = 16;
  localparam int DEF_TILE_WIDTH  = 16;
  localparam int DEF_TILE_HEIGHT = 16;
  localparam int NX_TILES = DEF_IMG_WIDTH / DEF_TILE_WIDTH;
  localparam int NY_TILES = DEF_IMG_HEIGHT / DEF_TILE_HEIGHT;
  localparam int N_TILES  = NX_TILES * NY_TILES;
  localparam int SUM_W = sum_w(DEF_TILE_WIDTH, DEF_TILE_HEIGHT);
  localparam int TX_W  = idx_w(NX_TILES);
  localparam int TY_W  = idx_w(NY_TILES);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [7:0]       mn;
    logic [7:0]       mx;
    logic [TX_W-1:0]  tx;
    logic [TY_W-1:0]  ty;
`ifdef TILE_STAT_MEAN_EN
    logic [7:0]       mean;
`endif
  } res_t;
endpackage

// File: rtl/tile_stat_accum_if.sv
// tile_stat_accum_if: pixel input and tile result handshake bundle.
// oRes_mean exists only with TILE_STAT_MEAN_EN.
interface tile_stat_accum_if #(parameter int SUM_W = 16, parameter int TX_W = 1, parameter int TY_W = 1);
  logic             iClear;
  logic             iValid;
  logic [7:0]       iData;
  logic             oRes_valid;
  logic             iRes_ready;
  logic [SUM_W-1:0] oRes_sum;
  logic [7:0]       oRes_min;
  logic [7:0]       oRes_max;
  logic [TX_W-1:0]  oRes_tile_x;
  logic [TY_W-1:0]  oRes_tile_y;
  logic             oFrame_done;
  logic             oOverflow;
`ifdef TILE_STAT_MEAN_EN
  logic [7:0]       oRes_mean;
`endif
  modport slave (
    input  iClear, iValid, iData, iRes_ready,
    output oRes_valid, oRes_sum, oRes_min, oRes_max, oRes_tile_x, oRes_tile_y, oFrame_done, oOverflow
`ifdef TILE_STAT_MEAN_EN
    , output oRes_mean
`endif
  );
  modport master (
    output iClear, iValid, iData, iRes_ready,
    input  oRes_valid, oRes_sum, oRes_min, oRes_max, oRes_tile_x, oRes_tile_y, oFrame_done, oOverflow
`ifdef TILE_STAT_MEAN_EN
    , input oRes_mean
`endif
  );
endinterface

// File: rtl/tile_stat_accum_fifo.sv
// tile_stat_fifo: synchronous first-word-fall-through FIFO; push is accepted when full if a pop frees the slot.
module tile_stat_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iFlush,
  input  logic         iPush,
  input  logic [W-1:0] iDin,
  input  logic         iPop,
  output logic [W-1:0] oDout,
  output logic         oFull,
  output logic         oEmpty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr, rd;
  logic         do_pop, do_push;
  assign oEmpty  = wr == rd;
  assign oFull   = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
  assign do_pop  = iPop && !oEmpty;
  assign do_push = iPush && (!oFull || do_pop);
  // Gated head keeps outputs at zero whenever nothing valid is stored.
  assign oDout   = oEmpty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      wr <= '0;
      rd <= '0;
    end else if (iFlush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
    end
  always_ff @(posedge iClk)
    if (do_push && !iFlush) mem[wr[AW-1:0]] <= iDin;
endmodule

// File: rtl/tile_stat_accum.sv
// tile_stat_accum: per-tile sum/min/max of a tile-ordered pixel stream, results queued in a FWFT FIFO.
// Define TILE_STAT_MEAN_EN to add a truncated mean field to each result.
module tile_stat_accum
  import tile_stat_pkg::*;
#(
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 16,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input logic               iClk,
  input logic               iRst,
  tile_stat_accum_if.slave  bus
);
  localparam int NPIX = TILE_WIDTH * TILE_HEIGHT;
  localparam int PW   = $clog2(NPIX);
  localparam int SW   = sum_w(TILE_WIDTH, TILE_HEIGHT);
  localparam int NX   = IMG_WIDTH / TILE_WIDTH;
  localparam int NY   = IMG_HEIGHT / TILE_HEIGHT;
  localparam int XW   = idx_w(NX);
  localparam int YW   = idx_w(NY);
  typedef struct packed {
    logic [SW-1:0] sum;
    logic [7:0]    mn;
    logic [7:0]    mx;
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;
`ifdef TILE_STAT_MEAN_EN
    logic [7:0]    mean;
`endif
  } rec_t;
  state_t        state, state_nx;
  logic [PW-1:0] pix_cnt;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;
  logic [SW-1:0] acc_sum, sum_nx;
  logic [7:0]    acc_min, acc_max, min_nx, max_nx;
  logic          take, last, last_tile, x_wrap, full, empty, pop, frame_done, overflow;
  rec_t          rec_in, rec_out;
  always_comb begin
    take      = bus.iValid && !bus.iClear && state != DONE;
    sum_nx    = acc_sum + SW'(bus.iData);
    min_nx    = bus.iData < acc_min ? bus.iData : acc_min;
    max_nx    = bus.iData > acc_max ? bus.iData : acc_max;
    last      = take && pix_cnt == PW'(NPIX - 1);
    x_wrap    = tx == XW'(NX - 1);
    last_tile = x_wrap && ty == YW'(NY - 1);
    state_nx  = bus.iClear ? IDLE :
                (state == IDLE && take) ? ACCUM :
                (last && last_tile) ? DONE : state;
  end
  always_comb begin
    rec_in      = '0;
    rec_in.sum  = sum_nx;
    rec_in.mn   = min_nx;
    rec_in.mx   = max_nx;
    rec_in.tx   = tx;
    rec_in.ty   = ty;
`ifdef TILE_STAT_MEAN_EN
    rec_in.mean = sum_nx[SW-1:PW];
`endif
  end
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) state <= IDLE;
    else       state <= state_nx;
  // Reset-value accumulators make the first pixel of every tile a plain accumulate step.
  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      pix_cnt    <= '0;
      tx         <= '0;
      ty         <= '0;
      acc_sum    <= '0;
      acc_min    <= 8'hFF;
      acc_max    <= 8'h00;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (bus.iClear) begin
      pix_cnt    <= '0;
      tx         <= '0;
      ty         <= '0;
      acc_sum    <= '0;
      acc_min    <= 8'hFF;
      acc_max    <= 8'h00;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= last && last_tile;
      if (last && full && !pop) overflow <= 1'b1;
      if (take) begin
        pix_cnt <= last ? '0 : pix_cnt + 1'b1;
        acc_sum <= last ? '0 : sum_nx;
        acc_min <= last ? 8'hFF : min_nx;
        acc_max <= last ? 8'h00 : max_nx;
        if (last) begin
          tx <= x_wrap ? '0 : tx + 1'b1;
          if (x_wrap) ty <= ty == YW'(NY - 1) ? '0 : ty + 1'b1;
        end
      end
    end
  assign pop = !empty && bus.iRes_ready;
  tile_stat_fifo #(.W($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iFlush (bus.iClear),
    .iPush  (last),
    .iDin   (rec_in),
    .iPop   (pop),
    .oDout  (rec_out),
    .oFull  (full),
    .oEmpty (empty)
  );
  assign bus.oRes_valid  = !empty;
  assign bus.oRes_sum    = rec_out.sum;
  assign bus.oRes_min    = rec_out.mn;
  assign bus.oRes_max    = rec_out.mx;
  assign bus.oRes_tile_x = rec_out.tx;
  assign bus.oRes_tile_y = rec_out.ty;
  assign bus.oFrame_done = frame_done;
  assign bus.oOverflow   = overflow;
`ifdef TILE_STAT_MEAN_EN
  assign bus.oRes_mean   = rec_out.mean;
`endif
endmodule
